// File: rtl/usb_aes_block_packer.sv
// Byte-to-block packer between USB RX and the AES core.
// Ports: clk/rst; byte_in/byte_valid/eop/byte_ready; blk_out/blk_last/blk_valid/blk_ready/blk_count.
module usb_aes_block_packer #(
  parameter int BLOCK_BYTES = 16,
  parameter int DEPTH       = 4,
  parameter int PAD_MODE    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  input  logic                         eop,
  output logic                         byte_ready,
  output logic [8*BLOCK_BYTES-1:0]     blk_out,
  output logic                         blk_last,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  output logic [$clog2(DEPTH+1)-1:0]   blk_count
);

  localparam int BW = 8*BLOCK_BYTES;
  localparam int CW = $clog2(BLOCK_BYTES+1);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(BLOCK_BYTES);

  typedef enum logic [1:0] {FILL, PAD, EXTRA, PUSH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   asm_q;
  logic            last_q;
  logic            extra_q;
  logic            rdy_en;

  logic [BW-1:0]   mem [DEPTH];
  logic [DEPTH-1:0] mem_last;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [NW-1:0]   count;

  logic            take;
  logic            solo_eop;
  logic            pop;
  logic            push;
  logic [CW-1:0]   cnt_nx;
  logic [7:0]      pad_val;

  // rdy_en holds byte_ready low for the first cycle after reset
  assign byte_ready = rdy_en && (state == FILL);
  assign take       = byte_valid & byte_ready;
  assign solo_eop   = eop & ~byte_valid & byte_ready;
  assign cnt_nx     = cnt + CW'(1);
  assign pad_val    = (PAD_MODE == 0) ? 8'h00
                    : 8'(BLOCK_BYTES - int'(cnt));

  assign blk_valid  = (count != '0);
  assign blk_count  = count;
  assign pop        = blk_valid & blk_ready;
  // a full FIFO still accepts when the head leaves this cycle
  assign push       = (state == PUSH)
                    && ((count < NW'(DEPTH)) || pop);
  assign blk_out    = blk_valid ? mem[rptr] : '0;
  assign blk_last   = blk_valid & mem_last[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      cnt     <= '0;
      asm_q   <= '0;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      rdy_en  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      unique case (state)
        FILL: begin
          if (take) begin
            asm_q[8*(BLOCK_BYTES-1-int'(cnt)) +: 8] <= byte_in;
            cnt <= cnt_nx;
            if (eop) begin
              if (cnt_nx != FULL) begin
                state <= PAD;
              end else begin
                // PKCS#7 needs a whole pad block after a full one
                state   <= PUSH;
                last_q  <= (PAD_MODE == 0);
                extra_q <= (PAD_MODE != 0);
              end
            end else if (cnt_nx == FULL) begin
              state  <= PUSH;
              last_q <= 1'b0;
            end
          end else if (solo_eop) begin
            if (cnt != '0) begin
              state <= PAD;
            end else if (PAD_MODE != 0) begin
              state <= EXTRA;
            end
          end
        end
        PAD: begin
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (i >= int'(cnt)) begin
              asm_q[8*(BLOCK_BYTES-1-i) +: 8] <= pad_val;
            end
          end
          last_q <= 1'b1;
          state  <= PUSH;
        end
        EXTRA: begin
          asm_q   <= {BLOCK_BYTES{8'(BLOCK_BYTES)}};
          last_q  <= 1'b1;
          extra_q <= 1'b0;
          state   <= PUSH;
        end
        PUSH: begin
          if (push) begin
            cnt    <= '0;
            asm_q  <= '0;
            last_q <= 1'b0;
            state  <= extra_q ? EXTRA : FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= asm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      mem_last <= '0;
    end else begin
      if (push) begin
        mem_last[wptr] <= last_q;
        wptr           <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + NW'(1);
      end else if (pop && !push) begin
        count <= count - NW'(1);
      end
    end
  end

endmodule

// File: tb/tb_usb_aes_block_packer.sv
// Bench for usb_aes_block_packer: PKCS#7 and zero-fill instances
// checked against a packet-level padding model plus literal vectors.
module tb_usb_aes_block_packer;

  logic         clk;
  logic         rst;
  logic [7:0]   byte_in1, byte_in0;
  logic         byte_valid1, byte_valid0;
  logic         eop1, eop0;
  logic         byte_ready1, byte_ready0;
  logic [127:0] blk_out1, blk_out0;
  logic         blk_last1, blk_last0;
  logic         blk_valid1, blk_valid0;
  logic         blk_ready1, blk_ready0;
  logic [2:0]   blk_count1, blk_count0;

  usb_aes_block_packer #(
    .BLOCK_BYTES(16), .DEPTH(4), .PAD_MODE(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .byte_in(byte_in1), .byte_valid(byte_valid1), .eop(eop1),
    .byte_ready(byte_ready1),
    .blk_out(blk_out1), .blk_last(blk_last1),
    .blk_valid(blk_valid1), .blk_ready(blk_ready1),
    .blk_count(blk_count1)
  );

  usb_aes_block_packer #(
    .BLOCK_BYTES(16), .DEPTH(4), .PAD_MODE(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .byte_in(byte_in0), .byte_valid(byte_valid0), .eop(eop0),
    .byte_ready(byte_ready0),
    .blk_out(blk_out0), .blk_last(blk_last0),
    .blk_valid(blk_valid0), .blk_ready(blk_ready0),
    .blk_count(blk_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops0 = 0;
  logic [7:0]   pkt1[$], pkt0[$];
  logic [128:0] exp1[$], exp0[$];
  bit           rand_rdy = 0;
  bit           stall1 = 0, stall0 = 0;
  logic [128:0] held1, held0;

  task automatic chk(input string name, input logic [131:0] act,
                     input logic [131:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pack(input logic [7:0] q[$],
                                        input int off);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = q[off+i];
    return r;
  endfunction

  task automatic emit(input int d, input logic [127:0] data,
                      input logic last);
    if (d == 1) exp1.push_back({last, data});
    else exp0.push_back({last, data});
  endtask

  // Close a packet: pad the leftover bytes and split into blocks.
  task automatic finish_pkt(input int d);
    logic [7:0] q[$];
    int n, pad, nb;
    if (d == 1) begin q = pkt1; pkt1.delete(); end
    else begin q = pkt0; pkt0.delete(); end
    n = q.size();
    if (d == 1) begin
      pad = 16 - (n % 16);
      repeat (pad) q.push_back(8'(pad));
    end else begin
      while (q.size() % 16 != 0) q.push_back(8'h00);
    end
    nb = q.size() / 16;
    for (int k = 0; k < nb; k++) emit(d, pack(q, 16*k), k == nb-1);
  endtask

  task automatic model_byte(input int d, input logic [7:0] b,
                            input logic e);
    if (d == 1) pkt1.push_back(b);
    else pkt0.push_back(b);
    if (e) finish_pkt(d);
    else if (d == 1 && pkt1.size() == 16) begin
      emit(1, pack(pkt1, 0), 1'b0);
      pkt1.delete();
    end else if (d == 0 && pkt0.size() == 16) begin
      emit(0, pack(pkt0, 0), 1'b0);
      pkt0.delete();
    end
  endtask

  task automatic check_pop(input int d, input logic [127:0] out,
                           input logic last);
    logic [128:0] e;
    bit have;
    have = (d == 1) ? (exp1.size() > 0) : (exp0.size() > 0);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL pop_unexpected%0d: got %0h, required no block",
               d, {last, out});
    end else begin
      if (d == 1) e = exp1.pop_front();
      else e = exp0.pop_front();
      if ({last, out} !== e) begin
        errors++;
        $display("FAIL pop_block%0d: got %0h, required %0h",
                 d, {last, out}, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp1.delete(); exp0.delete();
      pkt1.delete(); pkt0.delete();
      stall1 = 0; stall0 = 0;
    end else begin
      if (stall1)
        chk("hold1", {blk_valid1, blk_last1, blk_out1}, {1'b1, held1});
      if (byte_valid1 && byte_ready1) model_byte(1, byte_in1, eop1);
      else if (eop1 && byte_ready1) finish_pkt(1);
      if (blk_valid1 && blk_ready1) check_pop(1, blk_out1, blk_last1);
      stall1 = blk_valid1 && !blk_ready1;
      held1 = {blk_last1, blk_out1};

      if (stall0)
        chk("hold0", {blk_valid0, blk_last0, blk_out0}, {1'b1, held0});
      if (byte_valid0 && byte_ready0) model_byte(0, byte_in0, eop0);
      else if (eop0 && byte_ready0) finish_pkt(0);
      if (blk_valid0 && blk_ready0) begin
        check_pop(0, blk_out0, blk_last0);
        pops0++;
      end
      stall0 = blk_valid0 && !blk_ready0;
      held0 = {blk_last0, blk_out0};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) blk_ready1 = 1'($urandom_range(0, 1));
    end
  end

  // v=0 sends a standalone eop
  task automatic send(input int d, input logic [7:0] b,
                      input logic e, input logic v);
    bit acc;
    int n;
    n = 0;
    if (d == 1) begin byte_in1 = b; eop1 = e; byte_valid1 = v; end
    else begin byte_in0 = b; eop0 = e; byte_valid0 = v; end
    do begin
      acc = (d == 1) ? byte_ready1 : byte_ready0;
      step();
      n++;
    end while (!acc && n < 300);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout%0d: byte_ready 0, required 1", d);
    end
    if (d == 1) begin eop1 = 0; byte_valid1 = 0; end
    else begin eop0 = 0; byte_valid0 = 0; end
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (((d == 1) ? !blk_valid1 : !blk_valid0) && lat < 50) begin
      step();
      lat++;
    end
    chk("valid_seen", (d == 1) ? blk_valid1 : blk_valid0, 1);
  endtask

  task automatic drain1();
    int n;
    n = 0;
    blk_ready1 = 1;
    repeat (6) step();
    while (blk_count1 != 0 && n < 200) begin step(); n++; end
    chk("drain_count", blk_count1, 0);
  endtask

  initial begin
    int lat, p, total, len, pk;
    rst = 1;
    byte_in1 = 0; byte_in0 = 0;
    byte_valid1 = 0; byte_valid0 = 0;
    eop1 = 0; eop0 = 0;
    blk_ready1 = 0; blk_ready0 = 1;
    step(); step();
    chk("rst_valid", blk_valid1, 0);
    chk("rst_count", blk_count1, 0);
    chk("rst_out", {blk_last1, blk_out1}, 0);
    chk("rst_ready", byte_ready1, 0);
    rst = 0;
    chk("ready_before_edge", byte_ready1, 0);
    step();
    chk("ready_after_rst", byte_ready1, 1);
    chk("ready_after_rst0", byte_ready0, 1);

    // full block with eop: data block then a PKCS#7 block of 0x10
    blk_ready1 = 1;
    for (int i = 0; i < 16; i++) send(1, 8'(i), i == 15, 1);
    wait_valid(1, lat);
    chk("full_latency", lat, 1);
    chk("full_blk", {blk_last1, blk_out1},
        {1'b0, 128'h000102030405060708090A0B0C0D0E0F});
    step();
    wait_valid(1, lat);
    chk("extra_blk", {blk_last1, blk_out1}, {1'b1, {16{8'h10}}});
    repeat (3) step();
    chk("count_back0", blk_count1, 0);

    // short packet, PKCS#7 padding
    for (int i = 0; i < 5; i++) send(1, 8'hA0 + 8'(i), i == 4, 1);
    wait_valid(1, lat);
    chk("pad_latency", lat, 2);
    chk("pad_blk", {blk_last1, blk_out1},
        {1'b1, 40'hA0A1A2A3A4, {11{8'h0B}}});
    repeat (3) step();

    // zero fill with standalone eop, then eop on empty block
    send(0, 8'h11, 0, 1);
    send(0, 8'h22, 0, 1);
    send(0, 8'h33, 0, 1);
    send(0, 8'h00, 1, 0);
    wait_valid(0, lat);
    chk("zero_blk", {blk_last0, blk_out0}, {1'b1, 24'h112233, 104'h0});
    step();
    p = pops0;
    send(0, 8'h00, 1, 0);
    repeat (10) step();
    chk("empty_eop_none", pops0, p);
    chk("empty_eop_count", blk_count0, 0);

    // fill the FIFO and stall a fifth block in PUSH
    blk_ready1 = 0;
    for (int i = 0; i < 80; i++) send(1, 8'(i * 3 + 1), 0, 1);
    repeat (2) step();
    chk("full_count", blk_count1, 4);
    chk("full_stall_ready", byte_ready1, 0);
    blk_ready1 = 1;
    step();
    blk_ready1 = 0;
    chk("pushpop_count", blk_count1, 4);
    chk("pushpop_ready", byte_ready1, 1);
    send(1, 8'h00, 1, 0);
    drain1();

    // reset with two blocks queued and a partial block
    blk_ready1 = 0;
    for (int i = 0; i < 39; i++) send(1, 8'(i + 8'h40), 0, 1);
    chk("pre_rst_count", blk_count1, 2);
    rst = 1;
    step();
    chk("mid_rst_valid", blk_valid1, 0);
    chk("mid_rst_count", blk_count1, 0);
    chk("mid_rst_ready", byte_ready1, 0);
    rst = 0;
    blk_ready1 = 1;
    step();
    send(1, 8'hB0, 0, 1);
    send(1, 8'hB1, 0, 1);
    send(1, 8'hB2, 1, 1);
    wait_valid(1, lat);
    chk("post_rst_blk", {blk_last1, blk_out1},
        {1'b1, 24'hB0B1B2, {13{8'h0D}}});
    repeat (3) step();

    // random backpressure over about 1000 bytes
    rand_rdy = 1;
    total = 0;
    pk = 0;
    while (total < 1000) begin
      len = (pk == 5) ? 16 : (pk == 6) ? 32 : $urandom_range(1, 40);
      for (int i = 0; i < len; i++)
        send(1, 8'($urandom), (pk % 4 != 3) && (i == len-1), 1);
      if (pk % 4 == 3) send(1, 8'h00, 1, 0);
      total += len;
      pk++;
    end
    rand_rdy = 0;
    step();
    step();
    drain1();
    chk("model_empty", exp1.size(), 0);
    chk("model_empty0", exp0.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1);
  end

endmodule
